trap_ctrl: RTL and testbench

- Machine-mode trap controller for the NPC core. Sits directly downstream of the CLINT.
- Owns mstatus, mie, mtvec, mepc and mcause.
- Drives the MIE and MTIE enables into the CLINT and consumes its gated timer-interrupt line `tint`.
- On a trap or `mret` it updates CSRs and issues a one-cycle fetch redirect and flush to the pipeline at an instruction-commit boundary.

---
 rtl/trap_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl -- machine-mode trap controller for the NPC core.
//
// Owns mstatus, mie, mtvec, mepc and mcause. Sits downstream of the CLINT:
// it drives the MIE/MTIE enables into the CLINT and takes back the already
// gated timer interrupt `tint`. On ecall, timer interrupt or mret at a commit
// boundary it updates the CSRs and issues a one-cycle redirect + flush.
//
// Optional build macro: TRAP_VECTORED_EN
//   defined   : mtvec[0] is the mode bit; in mode 1 interrupts vector to
//               base + 4*cause[5:0], exceptions still go to base.
//   undefined : mtvec[1:0] is always 00 and every trap goes to base.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tint            gated timer interrupt from the CLINT
//   MIE, MTIE       mstatus.MIE and mie.MTIE register bits, to the CLINT
//   commit_*        retiring instruction: valid, pc, next pc, ecall, mret
//   csr_we/addr/wdata  CSR write port (from a retiring csr instruction)
//   csr_rdata, csr_hit combinational CSR read of csr_addr
//   busy            controller is in REDIRECT; upstream holds commit
//   redirect_valid, redirect_pc, flush  one-cycle fetch redirect to pipeline
module trap_ctrl #(
   parameter int               XLEN        = 64,
   parameter logic [XLEN-1:0]  RST_MSTATUS = 64'h1800
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tint,
   output logic            MIE,
   output logic            MTIE,
   input  logic            commit_valid,
   input  logic [XLEN-1:0] commit_pc,
   input  logic [XLEN-1:0] commit_npc,
   input  logic            commit_ecall,
   input  logic            commit_mret,
   input  logic            csr_we,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_hit,
   output logic            busy,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush
);

   localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(64'd11);
   localparam logic [XLEN-1:0] CAUSE_MTI   = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(64'd7);

   typedef enum logic [0:0] {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

   state_t          state_q;
   logic [XLEN-1:0] mstatus_q, mstatus_d;
   logic [XLEN-1:0] mie_q, mie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic            redir_valid_q;
   logic [XLEN-1:0] redir_pc_q;

   logic            take_ecall_s, take_int_s, take_mret_s, take_trap_s;
   logic            wr_mstatus_s, wr_mie_s, wr_mtvec_s, wr_mepc_s, wr_mcause_s;
   logic [XLEN-1:0] mtvec_base_s, target_s;

   // Trap decision: only at a commit while idle; ecall beats the interrupt,
   // and an mret commit never takes the interrupt on the same cycle.
   always_comb begin
      take_ecall_s = (state_q == IDLE) && commit_valid && commit_ecall;
      take_int_s   = (state_q == IDLE) && commit_valid && !commit_ecall && !commit_mret && tint;
      take_mret_s  = (state_q == IDLE) && commit_valid && !commit_ecall && commit_mret;
      take_trap_s  = take_ecall_s || take_int_s;
      wr_mstatus_s = csr_we && (csr_addr == 12'h300);
      wr_mie_s     = csr_we && (csr_addr == 12'h304);
      wr_mtvec_s   = csr_we && (csr_addr == 12'h305);
      wr_mepc_s    = csr_we && (csr_addr == 12'h341);
      wr_mcause_s  = csr_we && (csr_addr == 12'h342);
   end

   // Redirect target, latched into redir_pc_q when the decision is made.
   always_comb begin
      mtvec_base_s = {mtvec_q[XLEN-1:2], 2'b00};
      target_s     = mtvec_base_s;
      if (take_mret_s) begin
         target_s = mepc_q;
      end else begin
`ifdef TRAP_VECTORED_EN
         if (take_int_s && mtvec_q[0]) begin
            target_s = mtvec_base_s + XLEN'({CAUSE_MTI[5:0], 2'b00});
         end else begin
            target_s = mtvec_base_s;
         end
`else
         target_s = mtvec_base_s;
`endif
      end
   end

   // CSR next state: trap/mret updates win over a same-cycle CSR write.
   always_comb begin
      mstatus_d = mstatus_q;
      if (take_trap_s) begin
         mstatus_d[7] = mstatus_q[3];
         mstatus_d[3] = 1'b0;
      end else if (take_mret_s) begin
         mstatus_d[3] = mstatus_q[7];
         mstatus_d[7] = 1'b1;
      end else if (wr_mstatus_s) begin
         mstatus_d[3] = csr_wdata[3];
         mstatus_d[7] = csr_wdata[7];
      end else begin
         mstatus_d = mstatus_q;
      end

      mie_d = mie_q;
      if (wr_mie_s) begin
         mie_d    = '0;
         mie_d[7] = csr_wdata[7];
      end else begin
         mie_d = mie_q;
      end

      mtvec_d = mtvec_q;
      if (wr_mtvec_s) begin
`ifdef TRAP_VECTORED_EN
         mtvec_d = {csr_wdata[XLEN-1:2], 1'b0, csr_wdata[0]};
`else
         mtvec_d = {csr_wdata[XLEN-1:2], 2'b00};
`endif
      end else begin
         mtvec_d = mtvec_q;
      end

      mepc_d   = mepc_q;
      mcause_d = mcause_q;
      if (take_ecall_s) begin
         mepc_d   = {commit_pc[XLEN-1:2], 2'b00};
         mcause_d = CAUSE_ECALL;
      end else if (take_int_s) begin
         mepc_d   = {commit_npc[XLEN-1:2], 2'b00};
         mcause_d = CAUSE_MTI;
      end else begin
         if (wr_mepc_s) begin
            mepc_d = {csr_wdata[XLEN-1:2], 2'b00};
         end else begin
            mepc_d = mepc_q;
         end
         if (wr_mcause_s) begin
            mcause_d = csr_wdata;
         end else begin
            mcause_d = mcause_q;
         end
      end
   end

   // State, CSR registers and the registered redirect pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         mstatus_q     <= RST_MSTATUS;
         mie_q         <= '0;
         mtvec_q       <= '0;
         mepc_q        <= '0;
         mcause_q      <= '0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
      end else begin
         mstatus_q <= mstatus_d;
         mie_q     <= mie_d;
         mtvec_q   <= mtvec_d;
         mepc_q    <= mepc_d;
         mcause_q  <= mcause_d;
         case (state_q)
            IDLE: begin
               if (take_trap_s || take_mret_s) begin
                  state_q       <= REDIRECT;
                  redir_valid_q <= 1'b1;
                  redir_pc_q    <= target_s;
               end else begin
                  state_q       <= IDLE;
                  redir_valid_q <= 1'b0;
               end
            end
            REDIRECT: begin
               state_q       <= IDLE;
               redir_valid_q <= 1'b0;
            end
            default: begin
               state_q       <= IDLE;
               redir_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Combinational CSR read; MPP always reads as machine mode.
   always_comb begin
      csr_hit   = 1'b1;
      csr_rdata = '0;
      case (csr_addr)
         12'h300: csr_rdata = mstatus_q | XLEN'(64'h1800);
         12'h304: csr_rdata = mie_q;
         12'h305: csr_rdata = mtvec_q;
         12'h341: csr_rdata = mepc_q;
         12'h342: csr_rdata = mcause_q;
         default: begin
            csr_rdata = '0;
            csr_hit   = 1'b0;
         end
      endcase
   end

   assign MIE            = mstatus_q[3];
   assign MTIE           = mie_q[7];
   assign busy           = (state_q == REDIRECT);
   // A reset landing in the REDIRECT cycle suppresses that pulse too.
   assign redirect_valid = redir_valid_q && !rst;
   assign flush          = redir_valid_q && !rst;
   assign redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst, tint, commit_valid, commit_ecall, commit_mret, csr_we;
   logic [63:0] commit_pc, commit_npc, csr_wdata;
   logic [11:0] csr_addr;
   logic        MIE, MTIE, csr_hit, busy, redirect_valid, flush;
   logic [63:0] csr_rdata, redirect_pc;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] exp_q[$];

   trap_ctrl dut (
      .clk(clk), .rst(rst), .tint(tint), .MIE(MIE), .MTIE(MTIE),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_npc(commit_npc),
      .commit_ecall(commit_ecall), .commit_mret(commit_mret),
      .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_rdata(csr_rdata), .csr_hit(csr_hit), .busy(busy),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [11:0] a, output logic [63:0] v);
      csr_addr = a;
      #1;
      v = csr_rdata;
   endtask

   task automatic wr(input logic [11:0] a, input logic [63:0] d);
      csr_we = 1'b1; csr_addr = a; csr_wdata = d;
      tick();
      csr_we = 1'b0;
   endtask

   // Drive one commit; the expected redirect target is queued at drive time
   // and popped when the pulse appears. poke keeps an ecall on the commit
   // port during the REDIRECT cycle, which must be ignored.
   task automatic do_commit(input string nm, input logic [63:0] pc, input logic [63:0] npc,
                            input logic ec, input logic mr, input logic we, input logic [11:0] a,
                            input logic [63:0] wd, input logic exp_r, input logic [63:0] exp_pc,
                            input logic poke);
      logic [63:0] e;
      commit_valid = 1'b1; commit_pc = pc; commit_npc = npc;
      commit_ecall = ec; commit_mret = mr;
      csr_we = we; csr_addr = a; csr_wdata = wd;
      if (exp_r) exp_q.push_back(exp_pc);
      tick();
      csr_we = 1'b0;
      commit_valid = poke; commit_ecall = poke; commit_mret = 1'b0;
      total++;
      if (redirect_valid !== exp_r) begin
         bad++; $display("FAIL %s redirect_valid got=%b exp=%b", nm, redirect_valid, exp_r);
      end
      if (redirect_valid === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++; $display("FAIL %s unexpected redirect got=%h exp=none", nm, redirect_pc);
         end else begin
            e = exp_q.pop_front();
            if (redirect_pc !== e) begin
               bad++; $display("FAIL %s redirect_pc got=%h exp=%h", nm, redirect_pc, e);
            end
         end
         total++;
         if (flush !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL %s flush/busy got=%b/%b exp=1/1", nm, flush, busy);
         end
      end
      tick();
      commit_valid = 1'b0; commit_ecall = 1'b0;
      total++;
      if (redirect_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL %s pulse_end valid/busy got=%b/%b exp=0/0", nm, redirect_valid, busy);
      end
   endtask

   task automatic test_reset();
      logic [63:0] v0, v1, v2, v3, v4;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      rd(12'h300, v0); rd(12'h304, v1); rd(12'h305, v2); rd(12'h341, v3); rd(12'h342, v4);
      total++;
      if (v0 !== 64'h1800 || (v1 | v2 | v3 | v4) !== 64'h0) begin
         bad++; $display("FAIL reset_csrs got=%h/%h/%h/%h/%h exp=1800/0/0/0/0", v0, v1, v2, v3, v4);
      end
      total++;
      if ({MIE, MTIE, busy, redirect_valid, flush} !== 5'b00000) begin
         bad++; $display("FAIL reset_outs got=%b exp=00000", {MIE, MTIE, busy, redirect_valid, flush});
      end
      rd(12'h123, v0);
      total++;
      if (v0 !== 64'h0 || csr_hit !== 1'b0) begin
         bad++; $display("FAIL unmapped_csr got=%h/%b exp=0/0", v0, csr_hit);
      end
   endtask

   task automatic test_csr_write();
      logic [63:0] v;
      csr_we = 1'b1; csr_addr = 12'h300; csr_wdata = 64'h8;
      #1;
      total++;
      if (MIE !== 1'b0) begin
         bad++; $display("FAIL mie_no_bypass got=%b exp=0", MIE);
      end
      tick();
      csr_we = 1'b0;
      total++;
      if (MIE !== 1'b1) begin
         bad++; $display("FAIL mstatus_mie got=%b exp=1", MIE);
      end
      wr(12'h304, 64'hFFFF_FFFF_FFFF_FFFF);
      rd(12'h304, v);
      total++;
      if (MTIE !== 1'b1 || v !== 64'h80) begin
         bad++; $display("FAIL mie_mask got=%b/%h exp=1/80", MTIE, v);
      end
      wr(12'h305, 64'h8000_0100);
      rd(12'h305, v);
      total++;
      if (v !== 64'h8000_0100) begin
         bad++; $display("FAIL mtvec_wr got=%h exp=80000100", v);
      end
      wr(12'h341, 64'h8000_0007);
      rd(12'h341, v);
      total++;
      if (v !== 64'h8000_0004) begin
         bad++; $display("FAIL mepc_mask got=%h exp=80000004", v);
      end
      rd(12'h300, v);
      total++;
      if (v !== 64'h1808) begin
         bad++; $display("FAIL mstatus_rd got=%h exp=1808", v);
      end
   endtask

   task automatic test_timer_irq();
      logic [63:0] v0, v1, v2;
      tint = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++;
         if (redirect_valid !== 1'b0) begin
            bad++; $display("FAIL tint_pending got=%b exp=0", redirect_valid);
         end
      end
      do_commit("timer", 64'h8000_0010, 64'h8000_0014, 1'b0, 1'b0, 1'b0, 12'h0, 64'h0,
                1'b1, 64'h8000_0100, 1'b1);
      tint = 1'b0;
      rd(12'h341, v0); rd(12'h342, v1); rd(12'h300, v2);
      total++;
      if (v0 !== 64'h8000_0014 || v1 !== 64'h8000_0000_0000_0007 || v2 !== 64'h1880 || MIE !== 1'b0) begin
         bad++; $display("FAIL timer_csrs got=%h/%h/%h/%b exp=80000014/8000000000000007/1880/0", v0, v1, v2, MIE);
      end
   endtask

   task automatic test_mret_ecall();
      logic [63:0] v0, v1, v2;
      do_commit("mret1", 64'h8000_0050, 64'h8000_0054, 1'b0, 1'b1, 1'b0, 12'h0, 64'h0,
                1'b1, 64'h8000_0014, 1'b0);
      rd(12'h300, v0);
      total++;
      if (v0 !== 64'h1888 || MIE !== 1'b1) begin
         bad++; $display("FAIL mret1_mstatus got=%h/%b exp=1888/1", v0, MIE);
      end
      do_commit("ecall", 64'h8000_0020, 64'h8000_0024, 1'b1, 1'b0, 1'b0, 12'h0, 64'h0,
                1'b1, 64'h8000_0100, 1'b0);
      rd(12'h341, v0); rd(12'h342, v1); rd(12'h300, v2);
      total++;
      if (v0 !== 64'h8000_0020 || v1 !== 64'd11 || v2 !== 64'h1880) begin
         bad++; $display("FAIL ecall_csrs got=%h/%h/%h exp=80000020/b/1880", v0, v1, v2);
      end
      do_commit("mret2", 64'h8000_0060, 64'h8000_0064, 1'b0, 1'b1, 1'b0, 12'h0, 64'h0,
                1'b1, 64'h8000_0020, 1'b0);
      rd(12'h300, v0);
      total++;
      if (v0 !== 64'h1888) begin
         bad++; $display("FAIL mret2_mstatus got=%h exp=1888", v0);
      end
   endtask

   task automatic test_ecall_tint();
      logic [63:0] v0, v1, v2;
      tint = 1'b1;
      do_commit("ecall_tint", 64'h8000_0030, 64'h8000_0034, 1'b1, 1'b0, 1'b0, 12'h0, 64'h0,
                1'b1, 64'h8000_0100, 1'b0);
      rd(12'h342, v0); rd(12'h341, v1);
      total++;
      if (v0 !== 64'd11 || v1 !== 64'h8000_0030) begin
         bad++; $display("FAIL ecall_tint_csrs got=%h/%h exp=b/80000030", v0, v1);
      end
      do_commit("mret_tint", 64'h8000_0070, 64'h8000_0074, 1'b0, 1'b1, 1'b0, 12'h0, 64'h0,
                1'b1, 64'h8000_0030, 1'b0);
      rd(12'h342, v0); rd(12'h300, v1);
      total++;
      if (v0 !== 64'd11 || v1 !== 64'h1888) begin
         bad++; $display("FAIL mret_tint_csrs got=%h/%h exp=b/1888", v0, v1);
      end
      do_commit("tint_after_mret", 64'h8000_0080, 64'h8000_0084, 1'b0, 1'b0, 1'b0, 12'h0, 64'h0,
                1'b1, 64'h8000_0100, 1'b0);
      tint = 1'b0;
      rd(12'h342, v0); rd(12'h341, v1); rd(12'h300, v2);
      total++;
      if (v0 !== 64'h8000_0000_0000_0007 || v1 !== 64'h8000_0084 || v2 !== 64'h1880) begin
         bad++; $display("FAIL tint_after_mret_csrs got=%h/%h/%h exp=8000000000000007/80000084/1880", v0, v1, v2);
      end
   endtask

   task automatic test_csr_vs_trap();
      logic [63:0] v0, v1;
      do_commit("mret3", 64'h8000_0090, 64'h8000_0094, 1'b0, 1'b1, 1'b0, 12'h0, 64'h0,
                1'b1, 64'h8000_0084, 1'b0);
      tint = 1'b1;
      do_commit("tint_csrwr", 64'h8000_00A0, 64'h8000_00A4, 1'b0, 1'b0, 1'b1, 12'h300, 64'h0,
                1'b1, 64'h8000_0100, 1'b0);
      tint = 1'b0;
      rd(12'h300, v0);
      total++;
      if (v0 !== 64'h1880 || MIE !== 1'b0) begin
         bad++; $display("FAIL trap_wins_mstatus got=%h/%b exp=1880/0", v0, MIE);
      end
      do_commit("ecall_mtvecwr", 64'h8000_00B0, 64'h8000_00B4, 1'b1, 1'b0, 1'b1, 12'h305,
                64'h8000_0200, 1'b1, 64'h8000_0100, 1'b0);
      rd(12'h305, v0); rd(12'h341, v1);
      total++;
      if (v0 !== 64'h8000_0200 || v1 !== 64'h8000_00B0) begin
         bad++; $display("FAIL mtvec_wr_during_trap got=%h/%h exp=80000200/800000b0", v0, v1);
      end
   endtask

   task automatic test_reset_redirect();
      logic [63:0] v0, v1, v2, v3, v4;
      commit_valid = 1'b1; commit_ecall = 1'b1; commit_pc = 64'h8000_00C0; commit_npc = 64'h8000_00C4;
      tick();
      commit_valid = 1'b0; commit_ecall = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++; $display("FAIL rst_redirect_setup busy got=%b exp=1", busy);
      end
      rst = 1'b1;
      #1;
      total++;
      if (redirect_valid !== 1'b0 || flush !== 1'b0) begin
         bad++; $display("FAIL rst_abort_pulse got=%b/%b exp=0/0", redirect_valid, flush);
      end
      tick();
      rst = 1'b0;
      rd(12'h300, v0); rd(12'h304, v1); rd(12'h305, v2); rd(12'h341, v3); rd(12'h342, v4);
      total++;
      if (v0 !== 64'h1800 || (v1 | v2 | v3 | v4) !== 64'h0 || MIE !== 1'b0 || MTIE !== 1'b0) begin
         bad++; $display("FAIL rst_redirect_csrs got=%h/%h/%h/%h/%h/%b%b exp=1800/0/0/0/0/00", v0, v1, v2, v3, v4, MIE, MTIE);
      end
      tick();
      total++;
      if (redirect_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL rst_no_late_pulse got=%b/%b exp=0/0", redirect_valid, busy);
      end
   endtask

   task automatic test_vectored();
      logic [63:0] v;
      wr(12'h305, 64'h8000_0103);
      wr(12'h304, 64'h80);
      wr(12'h300, 64'h8);
      rd(12'h305, v);
`ifdef TRAP_VECTORED_EN
      total++;
      if (v !== 64'h8000_0101) begin
         bad++; $display("FAIL vec_mtvec got=%h exp=80000101", v);
      end
      tint = 1'b1;
      do_commit("vec_timer", 64'h8000_00D0, 64'h8000_00D4, 1'b0, 1'b0, 1'b0, 12'h0, 64'h0,
                1'b1, 64'h8000_011C, 1'b0);
      tint = 1'b0;
      do_commit("vec_mret", 64'h8000_00E0, 64'h8000_00E4, 1'b0, 1'b1, 1'b0, 12'h0, 64'h0,
                1'b1, 64'h8000_00D4, 1'b0);
      do_commit("vec_ecall", 64'h8000_00F0, 64'h8000_00F4, 1'b1, 1'b0, 1'b0, 12'h0, 64'h0,
                1'b1, 64'h8000_0100, 1'b0);
`else
      total++;
      if (v !== 64'h8000_0100) begin
         bad++; $display("FAIL direct_mtvec got=%h exp=80000100", v);
      end
      tint = 1'b1;
      do_commit("direct_timer", 64'h8000_00D0, 64'h8000_00D4, 1'b0, 1'b0, 1'b0, 12'h0, 64'h0,
                1'b1, 64'h8000_0100, 1'b0);
      tint = 1'b0;
`endif
   endtask

   initial begin
      rst = 1'b1; tint = 1'b0; commit_valid = 1'b0; commit_ecall = 1'b0; commit_mret = 1'b0;
      commit_pc = 64'h0; commit_npc = 64'h0; csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 64'h0;
      test_reset();
      test_csr_write();
      test_timer_irq();
      test_mret_ecall();
      test_ecall_tint();
      test_csr_vs_trap();
      test_reset_redirect();
      test_vectored();
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
